// File: rtl/key_pkg.sv
// Shared widths, state encoding and helpers for the keypad event controller.
package key_pkg;
  localparam int KEY_W  = 20;
  localparam int CODE_W = 5;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} key_state_t;
  typedef logic [CODE_W-1:0] key_code_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/key_prio_enc.sv
// Highest-index-wins encoder for the synchronized key vector; 0 when no key is set.
module key_prio_enc
  import key_pkg::*;
(
  input  logic [KEY_W-1:0] vec,
  output key_code_t        code
);

  always_comb begin
    code = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (vec[i]) code = key_code_t'(i);
    end
  end

endmodule

// File: rtl/key_ctrl.sv
// Keypad event controller: sync, priority select, debounce, auto-repeat and a
// one-entry valid/ready output register.
module key_ctrl
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 4800000,
  parameter int REPEAT_RATE     = 1200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] in,
  input  logic             key_ready,
  output logic             key_valid,
  output key_code_t        key_code,
  output logic             key_held,
  output logic             overrun
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [KEY_W-1:0] sync_meta, sync_vec;
  key_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  key_code_t        cur, cur_d, enc_code;
  logic             rep, rep_d;
  logic             emit, any, key_on;

  // Stage 0/1: two-flop synchronizer on the raw lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_vec  <= '0;
    end else begin
      sync_meta <= in;
      sync_vec  <= sync_meta;
    end
  end

  key_prio_enc u_enc (
    .vec  (sync_vec),
    .code (enc_code)
  );

  assign any    = |sync_vec;
  assign key_on = sync_vec[cur];

  // Stage 2: debounce / repeat FSM; every compare restarts cnt so it never wraps
  always_comb begin
    state_d = state;
    cnt_d   = cnt + CNT_W'(1);
    cur_d   = cur;
    rep_d   = rep;
    emit    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (any) begin
          cur_d   = enc_code;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!key_on) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt == DEB_LAST) begin
          emit    = 1'b1;
          cnt_d   = '0;
          rep_d   = 1'b0;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!key_on) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (REPEAT_DELAY == 0) begin
          cnt_d = '0;
        end else if (cnt == (rep ? RATE_LAST : DELAY_LAST)) begin
          emit  = 1'b1;
          cnt_d = '0;
          rep_d = 1'b1;
        end
      end
      RELEASE: begin
        if (key_on) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt == DEB_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= '0;
      rep   <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      cur   <= cur_d;
      rep   <= rep_d;
    end
  end

  // Stage 3: one-entry output register; a full register drops the event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (emit) begin
        if (!key_valid || key_ready) begin
          key_code  <= cur;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign key_held = (state == HELD) || (state == RELEASE);

endmodule

// File: tb/tb_key_ctrl.sv
// Directed and randomized checks of key_ctrl against a timestamp-based event model.
module tb_key_ctrl;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] in = '0;
  logic        key_ready = 1'b1;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_held;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  // Model: in delayed two samples, then phases driven by elapsed-time stamps.
  logic [19:0] m_s1, m_s2;
  int  m_phase;  // 0 idle, 1 pressing, 2 held, 3 releasing
  int  t_mark, m_cur, m_code, cyc;
  bit  m_rep, m_v, m_ovr;

  key_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic int highest(input logic [19:0] v);
    int h;
    h = 0;
    for (int i = 0; i < 20; i++) if (v[i]) h = i;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_phase = 0; t_mark = 0; m_cur = 0;
    m_rep = 0; m_v = 0; m_code = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit emit;
    emit = 0;
    case (m_phase)
      0: if (m_s2 != 0) begin m_cur = highest(m_s2); t_mark = cyc; m_phase = 1; end
      1: if (!m_s2[m_cur]) m_phase = 0;
         else if (cyc - t_mark == D) begin emit = 1; t_mark = cyc; m_rep = 0; m_phase = 2; end
      2: if (!m_s2[m_cur]) begin t_mark = cyc; m_phase = 3; end
         else if (RD != 0 && cyc - t_mark == (m_rep ? RR : RD)) begin
           emit = 1; t_mark = cyc; m_rep = 1;
         end
      default: if (m_s2[m_cur]) begin t_mark = cyc; m_phase = 2; end
               else if (cyc - t_mark == D) m_phase = 0;
    endcase
    m_ovr = 0;
    if (emit) begin
      if (!m_v || key_ready) begin m_code = m_cur; m_v = 1; end
      else m_ovr = 1;
    end else if (m_v && key_ready) begin
      m_v = 0;
    end
    m_s2 = m_s1;
    m_s1 = in;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    cyc++;
    #1;
    chk("model_valid", key_valid, m_v);
    chk("model_code", key_code, m_code);
    chk("model_held", key_held, (m_phase == 2 || m_phase == 3));
    chk("model_overrun", overrun, m_ovr);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [19:0] v;
    int len;
    cyc = 0;
    model_reset();

    // Reset state
    #2;
    chk("reset_valid", key_valid, 0);
    chk("reset_code", key_code, 0);
    chk("reset_held", key_held, 0);
    chk("reset_overrun", overrun, 0);
    ticks(2);
    rst = 1'b1;
    ticks(2);

    // Press key 7: event after edge 6, repeats after 16, 19, 22
    in = 20'd1 << 7;
    ticks(6);
    chk("press7_early_valid", key_valid, 0);
    tick();
    chk("press7_valid", key_valid, 1);
    chk("press7_code", key_code, 7);
    chk("press7_held", key_held, 1);
    for (int i = 7; i < 16; i++) begin
      tick();
      chk("press7_no_repeat", key_valid, 0);
    end
    tick();
    chk("repeat16_valid", key_valid, 1);
    chk("repeat16_code", key_code, 7);
    ticks(2);
    tick();
    chk("repeat19_valid", key_valid, 1);
    ticks(2);
    tick();
    chk("repeat22_valid", key_valid, 1);

    // Short release glitch keeps the cadence, then a real release
    in = '0;
    ticks(2);
    in = 20'd1 << 7;
    ticks(12);
    chk("glitch_held", key_held, 1);
    in = '0;
    ticks(6);
    chk("release_held_still", key_held, 1);
    tick();
    chk("release_held_fall", key_held, 0);
    ticks(4);

    // Press glitch on key 3 produces nothing
    in = 20'd1 << 3;
    ticks(3);
    in = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("glitch3_valid", key_valid, 0);
      chk("glitch3_held", key_held, 0);
    end

    // Keys 2 and 15 together; 19 added later is ignored until 15 leaves
    in = (20'd1 << 2) | (20'd1 << 15);
    ticks(7);
    chk("multi_valid", key_valid, 1);
    chk("multi_code", key_code, 15);
    in = in | (20'd1 << 19);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold15_code", key_code, 15);
    end
    in = (20'd1 << 19) | (20'd1 << 2);
    ticks(30);
    chk("after15_code", key_code, 19);
    in = '0;
    ticks(12);

    // Backpressure: repeat is dropped with a single overrun pulse
    key_ready = 1'b0;
    in = 20'd1 << 5;
    ticks(7);
    chk("bp_valid", key_valid, 1);
    chk("bp_code", key_code, 5);
    for (int i = 7; i < 16; i++) begin
      tick();
      chk("bp_no_overrun", overrun, 0);
    end
    tick();
    chk("bp_overrun", overrun, 1);
    chk("bp_valid_kept", key_valid, 1);
    chk("bp_code_kept", key_code, 5);
    tick();
    chk("bp_overrun_pulse", overrun, 0);
    key_ready = 1'b1;
    tick();
    chk("bp_drain", key_valid, 0);
    in = '0;
    ticks(12);

    // Reset in the middle of a held key with a pending event
    in = 20'd1 << 7;
    ticks(7);
    chk("pre_reset_valid", key_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_reset_valid", key_valid, 0);
    chk("async_reset_code", key_code, 0);
    chk("async_reset_held", key_held, 0);
    chk("async_reset_overrun", overrun, 0);
    in = 20'd1 << 9;
    ticks(3);
    rst = 1'b1;
    ticks(6);
    chk("post_reset_early", key_valid, 0);
    tick();
    chk("post_reset_valid", key_valid, 1);
    chk("post_reset_code", key_code, 9);
    chk("post_reset_held", key_held, 1);
    in = '0;
    ticks(12);

    // Randomized key activity with random backpressure
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = 20'd1 << $urandom_range(0, 19);
        2: v = (20'd1 << $urandom_range(0, 19)) | (20'd1 << $urandom_range(0, 19));
        default: v = 20'($urandom) & 20'($urandom) & 20'($urandom);
      endcase
      in = v;
      len = $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        key_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
